// File: rtl/win_scanner.sv
// win_scanner
//   Sequential four-in-a-row detector for a 7x7 Connect-4 board.
//   A start snapshots the board, then one (cell, direction) pair is
//   evaluated per clock in the order p = 4*cell + dir, p = 0..195.
//   The first hit ends the scan. With no hit, the full-board (draw)
//   flag is reported instead.
//
// Ports
//   CLOCK_50     in   system clock, rising edge
//   resetn       in   asynchronous active-low reset
//   start        in   scan request, accepted only while busy=0
//   board[97:0]  in   cell k at bits [97-2k : 96-2k], 00 empty / 01 P1 / 10 P2 / 11 invalid
//   busy         out  scan in progress
//   done         out  one-cycle pulse when a scan completes
//   winner[1:0]  out  winning code, 00 if none
//   win_cell[5:0] out first cell of the winning line
//   win_dir[1:0] out  0 right, 1 down, 2 down-right, 3 down-left
//   draw         out  no win and every cell holds 01 or 10
//   o_dbg_state  out  FSM state (0 idle, 1 scan, 2 done)
//
// Handshake: start is a level sampled on the rising edge. It is taken
// whenever the FSM is not in SCAN, including the cycle in which done is
// high. While busy=1 start is ignored.
module win_scanner (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic [97:0] board,
  output logic        busy,
  output logic        done,
  output logic [1:0]  winner,
  output logic [5:0]  win_cell,
  output logic [1:0]  win_dir,
  output logic        draw,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [97:0] r_snap;
  logic [2:0]  r_row;
  logic [2:0]  r_col;
  logic [5:0]  r_cell;
  logic [1:0]  r_dir;
  logic        r_done;
  logic [1:0]  r_winner;
  logic [5:0]  r_win_cell;
  logic [1:0]  r_win_dir;
  logic        r_draw;

  logic        w_accept;
  logic        w_hit;
  logic        w_last;
  logic        w_full;
  logic        w_ok;
  logic [5:0]  w_step;
  logic [5:0]  w_k1;
  logic [5:0]  w_k2;
  logic [5:0]  w_k3;
  logic [1:0]  w_c0;
  logic [1:0]  w_c1;
  logic [1:0]  w_c2;
  logic [1:0]  w_c3;
  logic [1:0]  w_cells [0:63];

  assign w_accept = start && (r_state != S_SCAN);
  assign w_last   = (r_cell == 6'd48) && (r_dir == 2'd3);

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_SCAN;
      S_SCAN:  if (w_hit || w_last) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_SCAN;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy        = (r_state == S_SCAN);
    o_dbg_state = r_state;
    done        = r_done;
    winner      = r_winner;
    win_cell    = r_win_cell;
    win_dir     = r_win_dir;
    draw        = r_draw;
  end

  // Snapshot unpacked into a 64-entry table; entries past cell 48 read as
  // empty so that out-of-board indices on bound-failed pairs are harmless.
  always_comb begin
    for (int k = 0; k < 64; k++) w_cells[k] = 2'b00;
    for (int k = 0; k < 49; k++) w_cells[k] = r_snap[97-2*k -: 2];
  end

  always_comb begin
    w_full = 1'b1;
    for (int k = 0; k < 49; k++) w_full = w_full & (w_cells[k][1] ^ w_cells[k][0]);
  end

  // Direction as a linear index step plus its board-edge bound
  always_comb begin
    w_step = 6'd1;
    w_ok   = 1'b0;
    case (r_dir)
      2'd0: begin w_step = 6'd1; w_ok = (r_col <= 3'd3); end
      2'd1: begin w_step = 6'd7; w_ok = (r_row <= 3'd3); end
      2'd2: begin w_step = 6'd8; w_ok = (r_row <= 3'd3) && (r_col <= 3'd3); end
      default: begin w_step = 6'd6; w_ok = (r_row <= 3'd3) && (r_col >= 3'd3); end
    endcase
  end

  assign w_k1 = r_cell + w_step;
  assign w_k2 = w_k1 + w_step;
  assign w_k3 = w_k2 + w_step;
  assign w_c0 = w_cells[r_cell];
  assign w_c1 = w_cells[w_k1];
  assign w_c2 = w_cells[w_k2];
  assign w_c3 = w_cells[w_k3];

  assign w_hit = w_ok && (w_c0 == w_c1) && (w_c0 == w_c2) && (w_c0 == w_c3) &&
                 ((w_c0 == 2'b01) || (w_c0 == 2'b10));

  // Datapath: snapshot, pair counters, result registers
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      r_snap     <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_cell     <= '0;
      r_dir      <= '0;
      r_done     <= 1'b0;
      r_winner   <= '0;
      r_win_cell <= '0;
      r_win_dir  <= '0;
      r_draw     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_snap     <= board;
        r_row      <= '0;
        r_col      <= '0;
        r_cell     <= '0;
        r_dir      <= '0;
        r_winner   <= '0;
        r_win_cell <= '0;
        r_win_dir  <= '0;
        r_draw     <= 1'b0;
      end else if (r_state == S_SCAN) begin
        if (w_hit) begin
          r_winner   <= w_c0;
          r_win_cell <= r_cell;
          r_win_dir  <= r_dir;
          r_draw     <= 1'b0;
          r_done     <= 1'b1;
        end else if (w_last) begin
          r_winner <= 2'b00;
          r_draw   <= w_full;
          r_done   <= 1'b1;
        end else if (r_dir == 2'd3) begin
          r_dir  <= 2'd0;
          r_cell <= r_cell + 6'd1;
          if (r_col == 3'd6) begin
            r_col <= 3'd0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
        end else begin
          r_dir <= r_dir + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_win_scanner.sv
module tb_win_scanner;

  logic        CLOCK_50;
  logic        resetn;
  logic        start;
  logic [97:0] board;
  logic        busy;
  logic        done;
  logic [1:0]  winner;
  logic [5:0]  win_cell;
  logic [1:0]  win_dir;
  logic        draw;
  logic [1:0]  o_dbg_state;

  int n_cmp;
  int n_err;
  int lat;
  logic [97:0] b_work;
  logic [97:0] b_row4;
  logic [97:0] b_col6;
  logic [97:0] b_diag;
  logic [97:0] b_full;
  logic [31:0] exp_q[$];

  win_scanner dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .start       (start),
    .board       (board),
    .busy        (busy),
    .done        (done),
    .winner      (winner),
    .win_cell    (win_cell),
    .win_dir     (win_dir),
    .draw        (draw),
    .o_dbg_state (o_dbg_state)
  );

  // Clock / reset
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input int k, input logic [1:0] code);
    b_work[97-2*k -: 2] = code;
  endtask

  // Drive start for one rising edge (E0); returns 1ns after E0
  task automatic start_scan(input logic [97:0] b);
    @(negedge CLOCK_50);
    board = b;
    start = 1'b1;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
  endtask

  // Count edges after E0 until done is seen; -1 on timeout
  task automatic wait_done(output int l);
    l = -1;
    for (int n = 1; n <= 300; n++) begin
      @(posedge CLOCK_50);
      #1;
      if (done) begin
        l = n;
        break;
      end
    end
  endtask

  // Compare result outputs against the front of the expected queue
  // (winner, win_cell, win_dir, draw pushed in that order)
  task automatic check_result(input string tag);
    check({tag, "_winner"},   {30'd0, winner},   exp_q.pop_front());
    check({tag, "_win_cell"}, {26'd0, win_cell}, exp_q.pop_front());
    check({tag, "_win_dir"},  {30'd0, win_dir},  exp_q.pop_front());
    check({tag, "_draw"},     {31'd0, draw},     exp_q.pop_front());
  endtask

  task automatic push_exp(input logic [1:0] w, input logic [5:0] c, input logic [1:0] d, input logic dr);
    exp_q.push_back({30'd0, w});
    exp_q.push_back({26'd0, c});
    exp_q.push_back({30'd0, d});
    exp_q.push_back({31'd0, dr});
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    resetn = 1'b0;
    start  = 1'b0;
    board  = '0;

    // Boards
    b_work = '0;
    for (int k = 0; k < 4; k++) put(k, 2'b01);
    b_row4 = b_work;

    b_work = '0;
    put(6, 2'b10); put(13, 2'b10); put(20, 2'b10); put(27, 2'b10);
    b_col6 = b_work;

    b_work = '0;
    put(3, 2'b01); put(9, 2'b01); put(15, 2'b01); put(21, 2'b01);
    put(24, 2'b10); put(32, 2'b10); put(40, 2'b10); put(48, 2'b10);
    b_diag = b_work;

    // Column pairs alternate, phase flips each row: no line of four anywhere
    b_work = '0;
    for (int r = 0; r < 7; r++)
      for (int c = 0; c < 7; c++)
        put(r*7 + c, ((((c/2) + r) % 2) == 0) ? 2'b01 : 2'b10);
    b_full = b_work;

    // Reset state
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    push_exp(2'b00, 6'd0, 2'd0, 1'b0);
    check_result("rst");
    check("rst_state", {30'd0, o_dbg_state}, 32'd0);
    @(negedge CLOCK_50);
    resetn = 1'b1;

    // Horizontal win at p=0
    start_scan(b_row4);
    check("row4_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("row4_lat", lat, 32'd1);
    check("row4_busy_done", {31'd0, busy}, 32'd0);
    push_exp(2'b01, 6'd0, 2'd0, 1'b0);
    check_result("row4");
    @(posedge CLOCK_50); #1;
    check("row4_done_pulse", {31'd0, done}, 32'd0);
    push_exp(2'b01, 6'd0, 2'd0, 1'b0);
    check_result("row4_hold");

    // Vertical win at cell 6, p=25
    start_scan(b_col6);
    wait_done(lat);
    check("col6_lat", lat, 32'd26);
    push_exp(2'b10, 6'd6, 2'd1, 1'b0);
    check_result("col6");

    // Two lines, lower p (down-left at cell 3, p=15) wins
    start_scan(b_diag);
    wait_done(lat);
    check("diag_lat", lat, 32'd16);
    push_exp(2'b01, 6'd3, 2'd3, 1'b0);
    check_result("diag");

    // Empty board: full scan, no draw
    start_scan('0);
    wait_done(lat);
    check("empty_lat", lat, 32'd196);
    push_exp(2'b00, 6'd0, 2'd0, 1'b0);
    check_result("empty");

    // Full board without a line: draw
    start_scan(b_full);
    wait_done(lat);
    check("full_lat", lat, 32'd196);
    push_exp(2'b00, 6'd0, 2'd0, 1'b1);
    check_result("full");

    // Board changes after the start edge: snapshot must be used
    start_scan(b_col6);
    board = b_row4;
    wait_done(lat);
    check("snap_lat", lat, 32'd26);
    push_exp(2'b10, 6'd6, 2'd1, 1'b0);
    check_result("snap");

    // start while busy is ignored
    start_scan(b_col6);
    repeat (4) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    board = b_row4;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    check("busy_start_busy", {31'd0, busy}, 32'd1);
    wait_done(lat);
    check("busy_start_lat", lat, 32'd21);
    push_exp(2'b10, 6'd6, 2'd1, 1'b0);
    check_result("busy_start");

    // start in the same cycle done is high is accepted
    start_scan(b_row4);
    wait_done(lat);
    check("bb_first_lat", lat, 32'd1);
    board = b_col6;
    start = 1'b1;
    @(posedge CLOCK_50); #1;
    start = 1'b0;
    check("bb_busy", {31'd0, busy}, 32'd1);
    check("bb_cleared_winner", {30'd0, winner}, 32'd0);
    wait_done(lat);
    check("bb_second_lat", lat, 32'd26);
    push_exp(2'b10, 6'd6, 2'd1, 1'b0);
    check_result("bb");

    // Reset mid-scan
    start_scan('0);
    repeat (49) @(posedge CLOCK_50);
    #1;
    resetn = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_state", {30'd0, o_dbg_state}, 32'd0);
    push_exp(2'b00, 6'd0, 2'd0, 1'b0);
    check_result("mid_rst");
    lat = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge CLOCK_50); #1;
      if (done) lat = 1;
      if (n == 5) resetn = 1'b1;
    end
    check("mid_rst_no_done", lat, 32'd0);
    check("mid_rst_idle", {31'd0, busy}, 32'd0);
    start_scan(b_diag);
    wait_done(lat);
    check("after_rst_lat", lat, 32'd16);
    push_exp(2'b01, 6'd3, 2'd3, 1'b0);
    check_result("after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/win_scanner.md
# win_scanner

Sequential four-in-a-row detector for the 7x7 Connect-4 board. It reads the packed 98-bit board that the insertion logic writes, scans every cell/direction pair in a fixed order, and reports the first winning line found. If there is no win, it reports whether the board is full. It sits between the board-assembly logic and the display/turn control, in the recognizer position that consumes the board.

## Interface
Parameters: none. Board geometry is fixed at 7 rows x 7 columns, 2 bits per cell.

Ports:
- CLOCK_50  in  1  system clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- start  in  1  request a scan. Sampled on the rising edge. Accepted only when busy=0.
- board  in  98  packed board. Cell k (k=0..48, row=k/7 with row 0 at top, col=k%7) occupies bits [97-2k : 96-2k]. Cell codes: 00 = empty, 01 = player 1, 10 = player 2, 11 = invalid (never matches).
- busy  out  1  high while a scan is in progress.
- done  out  1  one-cycle pulse when a scan completes.
- winner  out  2  01 or 10 if a line was found; otherwise 00.
- win_cell  out  6  index of the first cell of the winning line; 0 if there is no win.
- win_dir  out  2  direction of the winning line; 0 if there is no win.
- draw  out  1  high if there is no win and all 49 cells are 01 or 10.

## Operation
- States:
  - IDLE: after reset.
  - SCAN
  - DONE: holds results.
- Transitions:
  - IDLE/DONE with start=1 goes to SCAN. On that edge the block latches board into an internal snapshot, clears winner, win_cell, win_dir and draw, sets pair index p=0, and raises busy.
  - SCAN evaluates one pair per cycle, p = 4*cell + dir, in order 0..195.
  - A hit, or completion of p=195, moves the FSM to DONE.
  - start while busy=1 is ignored.
- Directions, with their bounds (the pair is skipped as a non-hit if the bound fails):
  - dir0: right (0,+1), requires col<=3.
  - dir1: down (+1,0), requires row<=3.
  - dir2: down-right (+1,+1), requires row<=3 and col<=3.
  - dir3: down-left (+1,-1), requires row<=3 and col>=3.
- Hit condition: all four cells are equal and the code is 01 or 10. On a hit:
  - winner = that code
  - win_cell = cell
  - win_dir = dir
  - draw = 0
  - Scanning stops at the first hit, so lower p wins ties.
- No hit after p=195: winner=00, and draw = AND over all 49 cells of (code==01 or code==10), computed from the snapshot.
- Snapshot: board changes during SCAN have no effect on the result.
- Cell/direction counters use bounded increments: col wraps 6->0 with a row increment, and dir wraps 3->0 with a cell increment. No arithmetic overflow is possible; the 6-bit cell index never exceeds 48.

## Timing
- Reset (asynchronous, any state): state=IDLE, busy=0, done=0, winner=00, win_cell=0, win_dir=0, draw=0, snapshot=0.
- Start accepted at edge E0:
  - busy=1 from E0.
  - Pair p is evaluated in the cycle following edge E0+p.
- Hit at pair p:
  - At edge E0+p+1: outputs update, done=1, busy=0.
  - At edge E0+p+2: done returns to 0.
- No hit: done at edge E0+196, which is the maximum latency.
- Results hold in DONE until the next accepted start or reset.
- start in the same cycle that done is high is accepted: DONE to SCAN.
- Reset asserted mid-scan aborts immediately. No done pulse is produced. After release, the block needs a new start.

## Test plan
- Cells 0-3 = 01, rest 00; start → done 1 cycle after the start edge, winner=01, win_cell=0, win_dir=0, draw=0.
- Cells 6, 13, 20, 27 = 10, rest empty → done at E0+26, winner=10, win_cell=6, win_dir=1.
- Cells 3, 9, 15, 21 = 01 (down-left) plus cells 24, 32, 40, 48 = 10 (down-right, p=98) → first hit reported: winner=01, win_cell=3, win_dir=3, done at E0+16.
- Empty board → done at E0+196, winner=00, draw=0.
- Full board with no four-in-a-row (e.g. pairs of columns alternating per row so no line forms) → done at E0+196, winner=00, draw=1.
- Board changed on the cycle after start → result reflects the latched board.
- start during busy → no restart.
- resetn low at E0+50 → all outputs 0 and no done pulse. A subsequent start completes normally.
